// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states,
// response latency and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Cycles from accept to the RESP cycle for a load or a word store.
    localparam int RESP_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // A half must sit on an even address and a word on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half out of the memory word and extend it.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (size)
            SZ_BYTE: load_data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~zero_ext & half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Overwrite only the addressed lane of the word read back from memory.
    always_comb begin
        merged = rdata;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, read-modify-write for sub-word
// stores, single-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int CHECK_ALIGN = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    lsu_state_t  state_next;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_err;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept  = (state == IDLE) && req_valid;
    assign req_err = (req_size == SZ_RSVD) ||
                     ((CHECK_ALIGN != 0) && is_misaligned(req_size, req_addr[1:0]));

    lsu_lane_mux u_lane_mux (
        .size      (lat_size),
        .zero_ext  (lat_unsigned),
        .lane      (lat_addr[1:0]),
        .rdata     (mem_rdata),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: errors skip memory, word stores skip the read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = lat_we ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; memory bus is quiet outside RD/WR.
    always_comb begin
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        case (state)
            IDLE: req_ready = 1'b1;
            RD: begin
                mem_read = 1'b1;
                mem_addr = {lat_addr[31:2], 2'b00};
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                mem_wdata = (lat_size == SZ_WORD) ? lat_wdata : merge_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = lat_err;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

    // Latch the request on accept, capture load data or merged word in RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            lat_err      <= 1'b0;
            rdata_q      <= 32'h0;
            merge_q      <= 32'h0;
        end else if (accept) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_err      <= req_err;
            rdata_q      <= 32'h0;
            merge_q      <= 32'h0;
        end else if (state == RD) begin
            if (lat_we) begin
                merge_q <= merged;
            end else begin
                rdata_q <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word-addressed memory model,
// transaction-level reference model and per-cycle compare.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    load_store_unit #(.CHECK_ALIGN(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read, write on rising edge.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] wword;
        logic        commit;
        int          lat;
        int          exp_rd;
        int          exp_wr;
    } txn_t;

    txn_t q[$];

    int          check_count = 0;
    int          pass_count  = 0;
    int          head_age    = 0;
    int          head_rd     = 0;
    int          head_wr     = 0;
    int          resp_pulses = 0;
    int          write_pulses = 0;
    logic        model_ready = 1'b1;
    logic [31:0] last_rdata  = 32'h0;
    logic        last_err    = 1'b0;
    logic [31:0] last_wdata  = 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: what a request must produce, from the ISA-level rules.
    function automatic txn_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        txn_t        t;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] field;
        int          sh;
        w        = ref_mem[addr[7:2]];
        t.maddr  = addr & 32'hFFFF_FFFC;
        t.err    = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        t.rdata  = 32'h0;
        t.wword  = 32'h0;
        t.commit = 1'b0;
        t.exp_rd = 0;
        t.exp_wr = 0;
        t.lat    = 1;
        sh       = 0;
        mask     = 32'hFFFF_FFFF;
        if (size == 2'b00) begin
            sh   = 8 * int'(addr[1:0]);
            mask = 32'h0000_00FF;
        end else if (size == 2'b01) begin
            sh   = 16 * int'(addr[1]);
            mask = 32'h0000_FFFF;
        end
        if (!t.err) begin
            if (!we) begin
                field = (w >> sh) & mask;
                if (!uns && size != 2'b10 && field > (mask >> 1)) field = field | ~mask;
                t.rdata  = field;
                t.lat    = 2;
                t.exp_rd = 1;
            end else begin
                t.wword  = (w & ~(mask << sh)) | ((wdata & mask) << sh);
                t.commit = 1'b1;
                t.exp_wr = 1;
                t.exp_rd = (size == 2'b10) ? 0 : 1;
                t.lat    = (size == 2'b10) ? 2 : 3;
            end
        end
        return t;
    endfunction

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (resp_valid) resp_pulses++;
        if (mem_write) write_pulses++;
        if (!rst_n) begin
            checkOutput("reset_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'h10);
            checkOutput("reset_data", resp_rdata | mem_addr | mem_wdata, 32'h0);
            head_age    = 0;
            head_rd     = 0;
            head_wr     = 0;
            model_ready = 1'b1;
        end else begin
            model_ready = (q.size() == 0);
            checkOutput("req_ready", {31'd0, req_ready}, {31'd0, model_ready});
            if (q.size() != 0) begin
                head_age++;
                if (mem_read) begin
                    head_rd++;
                    checkOutput("rd_addr", mem_addr, q[0].maddr);
                end
                if (mem_write) begin
                    head_wr++;
                    last_wdata = mem_wdata;
                    checkOutput("wr_addr", mem_addr, q[0].maddr);
                    checkOutput("wr_data", mem_wdata, q[0].wword);
                end
                if (head_age == q[0].lat) begin
                    checkOutput("resp_valid", {31'd0, resp_valid}, 32'h1);
                    checkOutput("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
                    checkOutput("resp_rdata", resp_rdata, q[0].rdata);
                    checkOutput("mem_reads", head_rd, q[0].exp_rd);
                    checkOutput("mem_writes", head_wr, q[0].exp_wr);
                    last_rdata = resp_rdata;
                    last_err   = resp_err;
                    if (q[0].commit) ref_mem[q[0].maddr[7:2]] = q[0].wword;
                    void'(q.pop_front());
                    head_age = 0;
                    head_rd  = 0;
                    head_wr  = 0;
                end else begin
                    checkOutput("resp_early", {31'd0, resp_valid}, 32'h0);
                end
            end else begin
                checkOutput("idle_resp", {31'd0, resp_valid}, 32'h0);
                checkOutput("idle_mem", {30'd0, mem_read, mem_write}, 32'h0);
            end
            if (!resp_valid) checkOutput("resp_quiet", {31'd0, resp_err} | resp_rdata, 32'h0);
            if (!mem_read && !mem_write) checkOutput("bus_quiet", mem_addr | mem_wdata, 32'h0);
        end
    end

    // Wait for the modelled IDLE cycle, present one request, record it on accept.
    task automatic issueRequest(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        while (!model_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!model_ready) checkOutput("ready_timeout", 32'h0, 32'h1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        q.push_back(model(we, size, uns, addr, wdata));
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("done_timeout", q.size(), 0);
        @(negedge clk); #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        issueRequest(we, size, uns, addr, wdata);
        waitDone();
    endtask

    initial begin
        int w0;
        int r0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = i;
            ref_mem[i] = i;
        end
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        checkOutput("lw_14", last_rdata, 32'h0000_0005);
        checkOutput("lw_14_err", {31'd0, last_err}, 32'h0);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00AB);
        checkOutput("sb_09_wdata", last_wdata, 32'h0000_AB02);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        checkOutput("lw_08", last_rdata, 32'h0000_AB02);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0C, 32'h80FF_7F01);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0);
        checkOutput("lb_0f", last_rdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0);
        checkOutput("lbu_0f", last_rdata, 32'h0000_0080);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0);
        checkOutput("lh_0e", last_rdata, 32'hFFFF_80FF);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0);
        checkOutput("lhu_0c", last_rdata, 32'h0000_7F01);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        checkOutput("lw_06_err", {31'd0, last_err}, 32'h1);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234);
        checkOutput("sh_03_err", {31'd0, last_err}, 32'h1);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        checkOutput("rsvd_err", {31'd0, last_err}, 32'h1);
        checkOutput("rsvd_rdata", last_rdata, 32'h0);

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h1E, 32'h0000_9876);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
        checkOutput("lw_1c", last_rdata, 32'h9876_0007);

        // Abort a sub-word store with reset while it sits in RD.
        w0 = write_pulses;
        issueRequest(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_BEEF);
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        checkOutput("rst_no_write", write_pulses - w0, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("lw_10_after_rst", last_rdata, 32'h0000_0004);

        // Word store held valid for six edges behind a busy sub-word store.
        w0 = write_pulses;
        r0 = resp_pulses;
        issueRequest(1'b1, 2'b00, 1'b0, 32'h01, 32'h0000_005A);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h18;
        req_wdata    = 32'hCAFE_F00D;
        begin
            logic accepted;
            logic will_accept;
            accepted = 1'b0;
            for (int k = 0; k < 6; k++) begin
                will_accept = model_ready && !accepted;
                @(posedge clk);
                if (will_accept) begin
                    q.push_back(model(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFE_F00D));
                    accepted = 1'b1;
                end
                @(negedge clk); #1;
            end
        end
        req_valid = 1'b0;
        waitDone();
        checkOutput("hold_writes", write_pulses - w0, 2);
        checkOutput("hold_resps", resp_pulses - r0, 2);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        checkOutput("lw_18", last_rdata, 32'hCAFE_F00D);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        checkOutput("lw_00", last_rdata, 32'h0000_5A00);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
